// File: rtl/kband_arrow_mem_writer.sv
// Packs a traceback-arrow byte stream little-endian into 32-bit words and writes them to
// consecutive RAM words over Avalon-MM. Optional address wrap at DEPTH-1: KBAND_WR_WRAP_EN.
//  state   | meaning
//  S_IDLE  | waiting for start
//  S_FILL  | accepting bytes into the word buffer
//  S_WRITE | Avalon write held until waitrequest drops
//  S_DONE  | one-cycle done pulse, then idle
//  S_HALT  | last RAM word written, input back-pressured until start
module kband_arrow_mem_writer #(
    parameter int ADDR_W = 13,
    parameter int DEPTH  = 8192
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_WRITE, S_DONE, S_HALT} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   CNT_MAX   = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [3:0]        be_q, be_d;
    logic [1:0]        lane_q, lane_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              full_q, full_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        be_d    = be_q;
        lane_d  = lane_q;
        last_d  = last_q;
        done_d  = 1'b0;
        full_d  = full_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FILL;
                    addr_d  = base_addr;
                    data_d  = '0;
                    be_d    = '0;
                    lane_d  = '0;
                    last_d  = 1'b0;
                    full_d  = 1'b0;
                    cnt_d   = '0;
                end
            end
            S_FILL: begin
                if (in_valid) begin
                    data_d[{lane_q, 3'b000} +: 8] = in_data;
                    be_d[lane_q] = 1'b1;
                    lane_d = lane_q + 2'd1;
                    last_d = in_last;
                    if (lane_q == 2'd3 || in_last) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!avm_waitrequest) begin
                    cnt_d  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    data_d = '0;
                    be_d   = '0;
                    lane_d = '0;
                    last_d = 1'b0;
                    if (last_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else if (addr_q == LAST_ADDR) begin
`ifdef KBAND_WR_WRAP_EN
                        addr_d  = '0;
                        state_d = S_FILL;
`else
                        full_d  = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_HALT;
`endif
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FILL;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            be_q    <= '0;
            lane_q  <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            full_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            be_q    <= be_d;
            lane_q  <= lane_d;
            last_q  <= last_d;
            done_q  <= done_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs are flops or single-state decodes of state_q.
    assign in_ready       = (state_q == S_FILL);
    assign avm_write      = (state_q == S_WRITE);
    assign avm_chipselect = (state_q == S_WRITE);
    assign avm_address    = addr_q;
    assign avm_writedata  = data_q;
    assign avm_byteenable = be_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = done_q;
    assign full           = full_q;
    assign word_count     = cnt_q;

endmodule

// File: tb/tb_kband_arrow_mem_writer.sv
// Directed bench for kband_arrow_mem_writer; honours KBAND_WR_WRAP_EN in the RAM-end step.
module tb_kband_arrow_mem_writer;
    localparam int ADDR_W = 13;

    logic              clk = 1'b0;
    logic              reset_n, start, in_valid, in_ready, in_last;
    logic [ADDR_W-1:0] base_addr, avm_address;
    logic [7:0]        in_data;
    logic              avm_chipselect, avm_write, avm_waitrequest;
    logic [3:0]        avm_byteenable;
    logic [31:0]       avm_writedata;
    logic              busy, done, full;
    logic [ADDR_W:0]   word_count;

    int tests_run = 0;
    int tests_failed = 0;
    int nw = 0;

    logic [ADDR_W-1:0] wq_addr[$];
    logic [31:0]       wq_data[$];
    logic [3:0]        wq_be[$];

    always #5 clk = ~clk;

    kband_arrow_mem_writer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write(avm_write),
        .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
        .avm_waitrequest(avm_waitrequest), .busy(busy), .done(done), .full(full),
        .word_count(word_count)
    );

    always @(posedge clk) begin
        if (avm_write && !avm_waitrequest) begin
            wq_addr.push_back(avm_address);
            wq_data.push_back(avm_writedata);
            wq_be.push_back(avm_byteenable);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] b);
        chk({tag, "_present"}, 32'(wq_addr.size() > idx), 1);
        if (wq_addr.size() > idx) begin
            chk({tag, "_addr"}, 32'(wq_addr[idx]), a);
            chk({tag, "_data"}, wq_data[idx], d);
            chk({tag, "_be"}, 32'(wq_be[idx]), 32'(b));
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] b);
        start = 1'b1;
        base_addr = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", 32'(busy), 0);
    endtask

    task automatic chk_word(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] b);
        chk({tag, "_write"}, 32'(avm_write), 1);
        chk({tag, "_cs"}, 32'(avm_chipselect), 1);
        chk({tag, "_ready"}, 32'(in_ready), 0);
        chk({tag, "_addr"}, 32'(avm_address), a);
        chk({tag, "_data"}, avm_writedata, d);
        chk({tag, "_be"}, 32'(avm_byteenable), 32'(b));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; base_addr = '0; in_valid = 1'b0;
        in_data = '0; in_last = 1'b0; avm_waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_write", 32'(avm_write), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_count", 32'(word_count), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // T1: full word
        do_start(13'h010);
        chk("t1_ready", 32'(in_ready), 1);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        chk_word("t1", 32'h010, 32'h44332211, 4'hF);
        @(negedge clk);
        chk("t1_done", 32'(done), 1);
        chk("t1_count", 32'(word_count), 1);
        @(negedge clk);
        chk("t1_done_end", 32'(done), 0);
        chk("t1_busy_end", 32'(busy), 0);
        chk_wr("t1_wr", nw, 32'h010, 32'h44332211, 4'hF); nw++;

        // T2: partial words; in_last without in_valid ignored
        do_start(13'h020);
        in_last = 1'b1;
        @(negedge clk);
        in_last = 1'b0;
        chk("t2_last_novalid_ready", 32'(in_ready), 1);
        chk("t2_last_novalid_write", 32'(avm_write), 0);
        send(8'hAA, 1'b0); send(8'hBB, 1'b0); send(8'hCC, 1'b1);
        chk_word("t2a", 32'h020, 32'h00CCBBAA, 4'h7);
        wait_idle();
        chk_wr("t2a_wr", nw, 32'h020, 32'h00CCBBAA, 4'h7); nw++;
        do_start(13'h030);
        send(8'h5A, 1'b1);
        chk_word("t2b", 32'h030, 32'h0000005A, 4'h1);
        wait_idle();
        chk_wr("t2b_wr", nw, 32'h030, 32'h0000005A, 4'h1); nw++;
        chk("t2b_count", 32'(word_count), 1);

        // T3: waitrequest stall
        do_start(13'h040);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
        avm_waitrequest = 1'b1;
        send(8'h04, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk_word("t3_hold", 32'h040, 32'h04030201, 4'hF);
            @(negedge clk);
        end
        chk("t3_no_early_write", 32'(wq_addr.size()), 32'(nw));
        chk("t3_count_stalled", 32'(word_count), 0);
        avm_waitrequest = 1'b0;
        @(negedge clk);
        chk("t3_done", 32'(done), 1);
        chk("t3_count", 32'(word_count), 1);
        chk("t3_one_write", 32'(wq_addr.size()), 32'(nw + 1));
        chk_wr("t3_wr", nw, 32'h040, 32'h04030201, 4'hF); nw++;
        wait_idle();

        // T4: end of RAM
        do_start(13'h1FFF);
        send(8'hA0, 1'b0); send(8'hA1, 1'b0); send(8'hA2, 1'b0); send(8'hA3, 1'b0);
        chk_word("t4_end", 32'h1FFF, 32'hA3A2A1A0, 4'hF);
        @(negedge clk);
        chk_wr("t4_wr_end", nw, 32'h1FFF, 32'hA3A2A1A0, 4'hF); nw++;
`ifdef KBAND_WR_WRAP_EN
        chk("t4w_full", 32'(full), 0);
        chk("t4w_ready", 32'(in_ready), 1);
        chk("t4w_addr", 32'(avm_address), 0);
        send(8'hA4, 1'b0); send(8'hA5, 1'b0); send(8'hA6, 1'b0); send(8'hA7, 1'b1);
        chk_word("t4w_wrap", 32'h0000, 32'hA7A6A5A4, 4'hF);
        wait_idle();
        chk_wr("t4w_wr_wrap", nw, 32'h0000, 32'hA7A6A5A4, 4'hF); nw++;
        chk("t4w_count", 32'(word_count), 2);
        chk("t4w_full_end", 32'(full), 0);
`else
        chk("t4_full", 32'(full), 1);
        chk("t4_done_halt", 32'(done), 1);
        chk("t4_busy", 32'(busy), 1);
        chk("t4_count", 32'(word_count), 1);
        in_valid = 1'b1;
        in_data  = 8'hA4;
        for (int i = 0; i < 4; i++) begin
            chk("t4_halt_ready", 32'(in_ready), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("t4_halt_done_end", 32'(done), 0);
        chk("t4_full_sticky", 32'(full), 1);
        chk("t4_no_more_writes", 32'(wq_addr.size()), 32'(nw));
`endif
        do_start(13'h050);
        chk("t4_full_cleared", 32'(full), 0);
        send(8'h77, 1'b1);
        wait_idle();
        chk_wr("t4_restart_wr", nw, 32'h050, 32'h00000077, 4'h1); nw++;

        // T5: reset mid-transfer
        do_start(13'h060);
        send(8'hE1, 1'b0); send(8'hE2, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 0);
        chk("t5_ready", 32'(in_ready), 0);
        chk("t5_write", 32'(avm_write), 0);
        chk("t5_data", avm_writedata, 0);
        chk("t5_be", 32'(avm_byteenable), 0);
        chk("t5_addr", 32'(avm_address), 0);
        repeat (3) @(negedge clk);
        chk("t5_no_write", 32'(wq_addr.size()), 32'(nw));
        reset_n = 1'b1;
        @(negedge clk);
        do_start(13'h010);
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b1);
        wait_idle();
        chk_wr("t5_wr", nw, 32'h010, 32'h44332211, 4'hF); nw++;
        chk("t5_count", 32'(word_count), 1);

        // T6: start during FILL ignored
        do_start(13'h070);
        send(8'h01, 1'b0); send(8'h02, 1'b0);
        do_start(13'h100);
        chk("t6_still_fill", 32'(in_ready), 1);
        send(8'h03, 1'b0); send(8'h04, 1'b0);
        send(8'h05, 1'b0); send(8'h06, 1'b0); send(8'h07, 1'b0); send(8'h08, 1'b1);
        wait_idle();
        chk_wr("t6_wr0", nw, 32'h070, 32'h04030201, 4'hF); nw++;
        chk_wr("t6_wr1", nw, 32'h071, 32'h08070605, 4'hF); nw++;
        chk("t6_count", 32'(word_count), 2);
        chk("total_writes", 32'(wq_addr.size()), 32'(nw));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
